// File: rtl/i2c_master_xfer.sv
// rtl/i2c_master_xfer.sv - byte-level I2C master: optional START, one WRITE or READ byte with ACK, optional STOP
module i2c_master_xfer #(
  parameter int PRER_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic [PRER_W-1:0] prer,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic              cmd_read,
  input  logic              cmd_stop,
  input  logic              ack_in,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              ack_out,
  output logic              done,
  output logic              busy,
  input  logic              scl_pad_i,
  output logic              scl_padoen_o,
  input  logic              sda_pad_i,
  output logic              sda_padoen_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PRER_W-1:0] prer_q, qcnt;
  logic [1:0]        quarter;
  logic [2:0]        bitcnt;
  logic [7:0]        din_q;
  logic [6:0]        sr;
  logic              ack_in_q, wr_q, rd_q, stop_q;
  logic              scl_last, sda_last;
  logic              active, stretch, q_end, accept;

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state == S_START) || (state == S_DATA) ||
                     (state == S_ACK)   || (state == S_STOP);
  // A released SCL that still reads low is being stretched by the slave.
  assign stretch   = active && scl_padoen_o && !scl_pad_i;
  assign q_end     = active && !stretch && (qcnt == prer_q);

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    scl_padoen_o = scl_last;
    sda_padoen_o = sda_last;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_start)                  state_nxt = S_START;
          else if (cmd_write || cmd_read) state_nxt = S_DATA;
          else if (cmd_stop)              state_nxt = S_STOP;
          else                            state_nxt = S_DONE;
        end
      end
      S_START: begin
        case (quarter)
          2'd0:    begin scl_padoen_o = scl_last; sda_padoen_o = 1'b1; end
          2'd1:    begin scl_padoen_o = 1'b1;     sda_padoen_o = 1'b1; end
          2'd2:    begin scl_padoen_o = 1'b1;     sda_padoen_o = 1'b0; end
          default: begin scl_padoen_o = 1'b0;     sda_padoen_o = 1'b0; end
        endcase
        if (q_end && quarter == 2'd3) begin
          if (wr_q || rd_q) state_nxt = S_DATA;
          else if (stop_q)  state_nxt = S_STOP;
          else              state_nxt = S_DONE;
        end
      end
      S_DATA: begin
        scl_padoen_o = (quarter == 2'd1) || (quarter == 2'd2);
        sda_padoen_o = wr_q ? din_q[bitcnt] : 1'b1;
        if (q_end && quarter == 2'd3 && bitcnt == 3'd0) state_nxt = S_ACK;
      end
      S_ACK: begin
        scl_padoen_o = (quarter == 2'd1) || (quarter == 2'd2);
        sda_padoen_o = wr_q ? 1'b1 : ack_in_q;
        if (q_end && quarter == 2'd3) state_nxt = stop_q ? S_STOP : S_DONE;
      end
      S_STOP: begin
        scl_padoen_o = (quarter != 2'd0);
        sda_padoen_o = (quarter == 2'd3);
        if (q_end && quarter == 2'd3) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      prer_q   <= '0;
      qcnt     <= '0;
      quarter  <= 2'd0;
      bitcnt   <= 3'd7;
      din_q    <= 8'h00;
      sr       <= 7'h00;
      dout     <= 8'h00;
      ack_out  <= 1'b0;
      ack_in_q <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      stop_q   <= 1'b0;
      busy     <= 1'b0;
      scl_last <= 1'b1;
      sda_last <= 1'b1;
    end else begin
      // Lines hold their last driven level whenever no phase is active.
      scl_last <= scl_padoen_o;
      sda_last <= sda_padoen_o;
      if (accept) begin
        prer_q   <= prer;
        din_q    <= din;
        ack_in_q <= ack_in;
        wr_q     <= cmd_write;
        rd_q     <= cmd_read && !cmd_write;
        stop_q   <= cmd_stop;
        qcnt     <= '0;
        quarter  <= 2'd0;
        bitcnt   <= 3'd7;
      end else if (active && !stretch) begin
        if (qcnt == prer_q) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
          if (state == S_DATA && quarter == 2'd3) bitcnt <= bitcnt - 3'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end
      if (q_end && quarter == 2'd2) begin
        if (state == S_DATA && rd_q) begin
          sr <= {sr[5:0], sda_pad_i};
          if (bitcnt == 3'd0) dout <= {sr, sda_pad_i};
        end
        if (state == S_ACK && wr_q) ack_out <= sda_pad_i;
        if (state == S_START)       busy    <= 1'b1;
      end
      if (q_end && quarter == 2'd3 && state == S_STOP) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_master_xfer.sv
// tb/tb_i2c_master_xfer.sv - directed and random commands against an I2C slave model and transaction-level reference
module tb_i2c_master_xfer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] prer = 16'd0;
  logic        cmd_valid = 1'b0, cmd_start = 1'b0, cmd_write = 1'b0, cmd_read = 1'b0, cmd_stop = 1'b0;
  logic        ack_in = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        cmd_ready, ack_out, done, busy;
  logic [7:0]  dout;
  logic        scl_pad_i, scl_padoen_o, sda_pad_i, sda_padoen_o;

  always #5 clk = ~clk;

  // Open-drain wired-AND bus with pull-ups.
  logic slv_scl_rel = 1'b1, slv_sda_rel = 1'b1;
  assign scl_pad_i = scl_padoen_o & slv_scl_rel;
  assign sda_pad_i = sda_padoen_o & slv_sda_rel;

  i2c_master_xfer #(.PRER_W(16)) dut (
    .wb_clk_i(clk), .arst_i(arst_n), .prer(prer),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_stop(cmd_stop),
    .ack_in(ack_in), .din(din), .dout(dout), .ack_out(ack_out), .done(done), .busy(busy),
    .scl_pad_i(scl_pad_i), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_pad_i), .sda_padoen_o(sda_padoen_o)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration, written only by the stimulus process.
  bit         cfg_rd = 1'b0, cfg_present = 1'b1;
  logic [7:0] cfg_data = 8'h00;
  int         cfg_bitn = 9, cfg_seq = 0;
  int         stretch_seq = 0, stretch_bit = 3, stretch_len = 0;
  bit         watch_busy = 1'b0;

  // Slave state, written only by the slave process.
  int   bitn = 9, seen_seq = 0, stretch_used = 0, stretch_left = 0;
  int   start_cnt = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_m_scl = 1'b1;
  logic rx_bits[$];
  bit   busy_dropped = 1'b0;

  always @(negedge clk) begin
    logic scl_now, sda_now, drv;
    if (cfg_seq != seen_seq) begin
      seen_seq    = cfg_seq;
      bitn        = cfg_bitn;
      slv_sda_rel = 1'b1;
      rx_bits.delete();
    end
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) slv_scl_rel = 1'b1;
    end else if (stretch_seq != stretch_used && bitn == stretch_bit && scl_padoen_o && !prev_m_scl) begin
      stretch_used = stretch_seq;
      slv_scl_rel  = 1'b0;
      stretch_left = stretch_len;
    end
    prev_m_scl = scl_padoen_o;
    scl_now = scl_padoen_o & slv_scl_rel;
    if (!scl_now) begin
      drv = 1'b1;
      if (cfg_rd) begin
        if (bitn < 8) drv = cfg_data[7-bitn];
      end else if (bitn == 8 && cfg_present) begin
        drv = 1'b0;
      end
      slv_sda_rel = drv;
    end
    sda_now = sda_padoen_o & slv_sda_rel;
    if (scl_now && prev_scl) begin
      if (prev_sda && !sda_now) begin
        start_cnt++;
        bitn = 0;
        rx_bits.delete();
      end
    end else if (scl_now && !prev_scl) begin
      rx_bits.push_back(sda_now);
      bitn++;
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
    if (watch_busy && !busy) busy_dropped = 1'b1;
  end

  // Transaction-level reference state.
  logic       m_busy = 1'b0, m_ack = 1'b0;
  logic [7:0] m_dout = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit s, input bit w, input bit r, input bit p, input logic [7:0] d,
                      input bit ai, input int pr, input logic [7:0] sd, input bit pres,
                      input int extra, output bit busy_mid);
    int guard, t0, lat, exp_lat;
    bit rd_eff;
    logic [7:0] cap;
    logic ackbit;
    rd_eff   = r && !w;
    busy_mid = 1'b0;
    guard    = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready", cmd_ready, 1);
    cfg_rd      = rd_eff;
    cfg_present = pres;
    cfg_data    = sd;
    cfg_bitn    = s ? 9 : 0;
    cfg_seq++;
    if (extra > 0) begin
      stretch_len = extra;
      stretch_seq++;
    end
    cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p;
    din = d; ack_in = ai; prer = 16'(pr);
    cmd_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 6000; i++) begin
      if (rx_bits.size() == 4) busy_mid = busy;
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    exp_lat = 1 + 4 * (pr + 1) * (int'(s) + ((w || r) ? 9 : 0) + int'(p)) + extra;
    check("done_latency", lat, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (s) m_busy = 1'b1;
    if (w) m_ack = !pres;
    else if (rd_eff) m_dout = sd;
    if (p) m_busy = 1'b0;
    check("dout", dout, m_dout);
    check("ack_out", ack_out, m_ack);
    check("busy", busy, m_busy);
    if (w || rd_eff) begin
      cap = 'x;
      ackbit = 1'bx;
      if (rx_bits.size() >= 9) begin
        for (int i = 0; i < 8; i++) cap = {cap[6:0], rx_bits[i]};
        ackbit = rx_bits[8];
      end
      check("bus_byte", cap, w ? d : sd);
      check("bus_ack_bit", ackbit, w ? !pres : ai);
    end
  endtask

  initial begin
    bit bm;
    int sc0;
    bit s, w, r, p, ai, pres;
    logic [7:0] d, sd;
    int pr;

    repeat (3) @(negedge clk);
    check("rst_scl_oen", scl_padoen_o, 1);
    check("rst_sda_oen", sda_padoen_o, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_ack_out", ack_out, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // Write 0x20 with START/STOP, slave ACKs.
    xfer(1, 1, 0, 1, 8'h20, 0, 4, 8'h00, 1, 0, bm);
    check("write_busy_mid", bm, 1);
    check("write_scl_released", scl_padoen_o, 1);
    check("write_sda_released", sda_padoen_o, 1);

    // Bare read, NACK from master, slave sends 0xA5.
    xfer(0, 0, 1, 0, 8'h00, 1, 0, 8'hA5, 1, 0, bm);

    // Write to an absent slave.
    xfer(1, 1, 0, 1, 8'h3C, 0, 1, 8'h00, 0, 0, bm);

    // Slave stretches SCL during bit 3.
    stretch_bit = 3;
    xfer(1, 1, 0, 1, 8'hB7, 0, 2, 8'h00, 1, 10, bm);

    // Repeated START while the bus is held.
    xfer(1, 1, 0, 0, 8'h5A, 0, 1, 8'h00, 1, 0, bm);
    sc0 = start_cnt;
    watch_busy = 1'b1;
    xfer(1, 0, 1, 0, 8'h00, 0, 1, 8'hC3, 1, 0, bm);
    watch_busy = 1'b0;
    check("rstart_sda_fall", start_cnt - sc0, 1);
    check("rstart_busy_held", busy_dropped, 0);
    xfer(0, 0, 0, 1, 8'h00, 0, 1, 8'h00, 1, 0, bm);

    // Empty command and write-wins-over-read.
    xfer(0, 0, 0, 0, 8'h00, 0, 3, 8'h00, 1, 0, bm);
    xfer(1, 1, 1, 1, 8'h81, 1, 0, 8'h7E, 1, 0, bm);

    for (int k = 0; k < 12; k++) begin
      s = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
      ai = 1'($urandom_range(0, 1)); pres = 1'($urandom_range(0, 1));
      d = 8'($urandom); sd = 8'($urandom); pr = $urandom_range(0, 3);
      xfer(s, w, r, p, d, ai, pr, sd, pres, 0, bm);
    end

    // Reset in the middle of a byte.
    while (!cmd_ready) @(negedge clk);
    cfg_rd = 1'b0; cfg_present = 1'b1; cfg_bitn = 9; cfg_seq++;
    cmd_start = 1; cmd_write = 1; cmd_read = 0; cmd_stop = 1;
    din = 8'h96; prer = 16'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    check("midbyte_busy", busy, 1);
    #2 arst_n = 1'b0;
    #1;
    check("arst_scl_oen", scl_padoen_o, 1);
    check("arst_sda_oen", sda_padoen_o, 1);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    arst_n = 1'b1;
    m_busy = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
    check("arst_dout", dout, 0);
    @(negedge clk);
    xfer(1, 1, 0, 1, 8'hE1, 0, 1, 8'h00, 1, 0, bm);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_xfer.md
Name: i2c_master_xfer

Overview:
- Byte-level I2C master controller. It is the initiator that drives the bus toward an I2C slave model.
- Accepts one command per handshake: optional START, then one WRITE or READ byte with its ACK bit, then optional STOP.
- Generates SCL and SDA as open-drain enables, waits while a slave stretches SCL, and reports the received data and ACK.
- Sits between a register or bus front end and the I2C pads.

Parameters:
- PRER_W, 16, width of the prescale input.

Ports:
- wb_clk_i  in  1  system clock; all logic runs on the rising edge.
- arst_i  in  1  asynchronous reset, active low.
- prer  in  PRER_W  quarter-bit period minus 1, in clocks. Latched when a command is accepted.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  controller is able to accept a command.
- cmd_start  in  1  issue a START (or repeated START) first.
- cmd_write  in  1  transmit din, then sample the slave's ACK.
- cmd_read  in  1  receive a byte into dout, then drive ack_in.
- cmd_stop  in  1  issue a STOP last.
- ack_in  in  1  ACK value driven after a read: 0 = ACK, 1 = NACK.
- din  in  8  byte to transmit, MSB first.
- dout  out  8  last received byte.
- ack_out  out  1  ACK sampled from the slave after a write (0 = ACKed).
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  bus owned: set by START, cleared by STOP.
- scl_pad_i  in  1  SCL pin value.
- scl_padoen_o  out  1  SCL output enable, active low. 1 = released; 0 = pull the line low.
- sda_pad_i  in  1  SDA pin value.
- sda_padoen_o  out  1  SDA output enable, active low. 1 = released; 0 = pull the line low.

Behaviour:
- Reset values: scl_padoen_o=1, sda_padoen_o=1, cmd_ready=1, done=0, busy=0, dout=0, ack_out=0, FSM in IDLE.
- Reset mid-transfer releases both lines immediately.
- Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE. din, ack_in, prer and all flags are latched at acceptance.
- Command flag rules:
  - If both cmd_write and cmd_read are set, the write wins and the read is ignored.
  - An all-zero command causes no bus activity and pulses done on the next cycle.
- Timing unit: a quarter lasts prer+1 clocks. Each bit-time (START, data bit, ACK bit, STOP) is four quarters, q0 to q3.
- Clock stretching: in a quarter where SCL is released, the quarter counter holds while scl_pad_i==0 and only counts once it reads 1.
- FSM: IDLE -> START? -> (WRITE | READ)? -> ACK (if a byte was sent or received) -> STOP? -> IDLE. done pulses in the cycle after the last quarter ends.
- START quarters:
  - q0: SCL kept at its prior state, SDA released.
  - q1: SCL released (stretch applies).
  - q2: SDA driven low.
  - q3: SCL driven low.
  - Sets busy at the end of q2.
  - A repeated START issued while busy=1 follows the same sequence.
- WRITE bit quarters:
  - q0: SCL low; SDA set to the current bit (1 = released).
  - q1 and q2: SCL released.
  - q3: SCL low.
  - Bit counter runs 7 down to 0, MSB first.
- READ bit: same SCL pattern as WRITE with SDA released. sda_pad_i is sampled at the end of q2 and shifted into the LSB of the shift register. dout updates after bit 0.
- ACK bit:
  - After a write: SDA released; sda_pad_i sampled at the end of q2 into ack_out.
  - After a read: SDA driven to ack_in.
- STOP quarters:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2: SDA held low.
  - q3: SDA released.
  - Clears busy at the end of q3.
- Between commands without a STOP, SCL stays driven low and SDA keeps its last value.
- Bus duration of a command is 4*(prer+1)*N clocks plus any stretch, where N = number of bit-times (START=1, byte=8, ACK=1, STOP=1).

Test Plan:
- Write path: prer=4; command start+write+stop, din=8'h20; slave ACKs. Required: pattern 0,0,1,0,0,0,0,0 on SDA, sampled at SCL rise. ack_out=0. done pulses exactly 221 clocks after acceptance. busy is 1 between START and STOP. Both lines end released.
- Read path: prer=0; command read with ack_in=1; slave drives 8'hA5. Required: dout=8'hA5 and SDA released during the ACK bit. done after 37 clocks.
- NACK: command write of 8'h3C to an absent slave (SDA stays high). Required: ack_out=1 and done still pulses.
- Clock stretching: slave holds SCL low for 10 extra clocks in bit 3 of a write. Required: done is delayed by exactly 10 clocks and the data is unchanged.
- Repeated START: start+write, then start+read while busy=1. Required: SDA falls while SCL is high on the second START, and busy never deasserts.
- Reset: assert arst_i in the middle of a byte. Required: scl_padoen_o=1 and sda_padoen_o=1 immediately, cmd_ready=1, busy=0.
